// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier datapath and its controller.
package mult_pkg;

    localparam int WIDTH = 8;

    // One operation per cycle; the encoding order mirrors strobe priority.
    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_SHIFT  = 3'd1,
        OP_ADD    = 3'd2,
        OP_SUB    = 3'd3,
        OP_CLR_LD = 3'd4
    } op_e;

    // Resolve simultaneous strobes: Clr_Ld > Sub > Add > Shift.
    // Reset sits above all of these and is handled in the register block.
    function automatic op_e op_decode(input logic clr_ld, input logic sub,
                                      input logic add, input logic shift);
        op_e op;
        op = OP_NONE;
        if (clr_ld)     op = OP_CLR_LD;
        else if (sub)   op = OP_SUB;
        else if (add)   op = OP_ADD;
        else if (shift) op = OP_SHIFT;
        return op;
    endfunction

endpackage

// File: rtl/adder9.sv
// Add/subtract unit: s = a + b, or a + ~b + 1 when sub is set. Carry out is dropped.
module adder9 #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] s
);

    logic [N-1:0] b_eff;

    // Invert b and inject carry-in of one for subtraction.
    always_comb begin
        b_eff = sub ? ~b : b;
        s     = a + b_eff + {{(N-1){1'b0}}, sub};
    end

endmodule

// File: rtl/mult_datapath.sv
// Datapath of a signed shift-add multiplier: registers X, A, B and one add/sub unit.
// Sequencing lives in the external controller; this block only executes strobes.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clr_Ld,
    input  logic             Shift,
    input  logic             Add,
    input  logic             Sub,
    input  logic [WIDTH-1:0] S,
    output logic             X,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic [WIDTH-1:0] Bin
);

    logic             x_q, x_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   sum;
    op_e              op;

    assign op = op_decode(Clr_Ld, Sub, Add, Shift);

    // Sign-extend both operands so the WIDTH+1 result is always exact; X takes its top bit.
    adder9 #(.N(WIDTH + 1)) u_adder (
        .a   ({a_q[WIDTH-1], a_q}),
        .b   ({S[WIDTH-1], S}),
        .sub (op == OP_SUB),
        .s   (sum)
    );

    // Next-state selection for the single operation chosen this cycle.
    always_comb begin
        x_d = x_q;
        a_d = a_q;
        b_d = b_q;
        case (op)
            OP_CLR_LD: begin
                x_d = 1'b0;
                a_d = '0;
                b_d = S;
            end
            OP_SUB, OP_ADD: begin
                x_d = sum[WIDTH];
                a_d = sum[WIDTH-1:0];
            end
            OP_SHIFT: begin
                a_d = {x_q, a_q[WIDTH-1:1]};
                b_d = {a_q[0], b_q[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

    // State registers with synchronous reset overriding every strobe.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            x_q <= x_d;
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign X    = x_q;
    assign Aval = a_q;
    assign Bval = b_q;
    assign Bin  = b_q;

endmodule

// File: doc/mult_datapath.md
MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the operand width in bits; all widths below are stated for WIDTH=8.
REQ-002 The module SHALL have port Clk, input, 1 bit: the single system clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port Clr_Ld, input, 1 bit: clear X and A, and load B from S.
REQ-005 The module SHALL have port Shift, input, 1 bit: arithmetic right shift of the concatenation {X,A,B}.
REQ-006 The module SHALL have port Add, input, 1 bit: {X,A} <= A + S, signed, 9 bits.
REQ-007 The module SHALL have port Sub, input, 1 bit: {X,A} <= A - S, signed, 9 bits.
REQ-008 The module SHALL have port S, input, 8 bits: switch operand, two's complement.
REQ-009 The module SHALL have port X, output, 1 bit: sign-extension register.
REQ-010 The module SHALL have port Aval, output, 8 bits: register A, the product high byte.
REQ-011 The module SHALL have port Bval, output, 8 bits: register B, the multiplier and product low byte.
REQ-012 The module SHALL have port Bin, output, 8 bits: a copy of B, fed back to the controller, which samples Bin[0].

Function
REQ-013 X, A and B SHALL be registers, and all outputs SHALL be direct register outputs with no combinational path from any input to any output.
REQ-014 At most one operation SHALL execute per cycle, in priority order Reset > Clr_Ld > Sub > Add > Shift; lower-priority strobes asserted in the same cycle SHALL be ignored.
REQ-015 Clr_Ld SHALL give X<=0, A<=0x00, B<=S on the next edge.
REQ-016 Add SHALL give {X,A} <= sext9(A) + sext9(S), discarding the carry out of bit 8; B SHALL be unchanged.
REQ-017 Sub SHALL give {X,A} <= sext9(A) + ~sext9(S) + 1, discarding the carry out of bit 8; B SHALL be unchanged.
REQ-018 Shift SHALL give X<=X, A<={X,A[7:1]}, B<={A[0],B[7:1]}.
REQ-019 With no strobe asserted, all registers SHALL hold their values.
REQ-020 Each operation's latency SHALL be one cycle, so Bin[0] reflects the new B in the cycle following a Shift, which is the cycle in which the controller samples it.
REQ-021 Signed overflow of A SHALL be absorbed by X, since the 9-bit sum is always exact for 8-bit signed operands.
REQ-022 S SHALL be sampled only on an edge on which Clr_Ld, Add or Sub is acting, and its value at any other time SHALL not matter.

Reset
REQ-023 When Reset is high at a rising edge of Clk, X SHALL become 0, A 0x00 and B 0x00, regardless of any strobe.
REQ-024 Reset asserted mid-multiplication SHALL abort the operation, and the first edge after deassertion SHALL behave as an idle cycle unless a strobe is asserted.

Structure
REQ-025 The 9-bit add/subtract SHALL be implemented as a sub-module adder9, with inputs a[8:0], b[8:0], sub and output s[8:0], where sub inverts b and sets carry-in to 1.
REQ-026 WIDTH and the operation-priority encoding SHALL live in the shared package mult_pkg, which is also used by the controller.
REQ-027 The module SHALL contain no state machine, and sequencing SHALL remain entirely in the controller.

Verification
REQ-028 The bench SHALL check: Reset with S=0xAA and Clr_Ld=1 in the same cycle -> X=0, A=0x00, B=0x00.
REQ-029 The bench SHALL check: Clr_Ld with S=0x07, then a full controller-accurate sequence of 7 add/shift pairs plus a final sub/shift with S=0xFD -> X=1, A=0xFF, B=0xEB (-21).
REQ-030 The bench SHALL check: load B=0x80 and multiply by S=0x80 -> X=0, A=0x40, B=0x00 (+16384).
REQ-031 The bench SHALL check: A=0x7F, Add with S=0x01 -> X=0, A=0x80; then Shift -> A=0x40, with B[7]=old A[0]=0.
REQ-032 The bench SHALL check: A=0x00, Sub with S=0x01 -> X=1, A=0xFF; Add and Shift asserted together with S=0x01 -> only the Add executes, giving A=0x00, X=0.
REQ-033 The bench SHALL check: an idle stretch of 10 cycles with S toggling randomly -> X, A and B unchanged.
